// File: rtl/types_pkg.sv
// Shared pipeline types: opcode constants, instruction details and the
// memory-access state used by the MEM/WB stage.
package types;

    // Opcode encoding carried in InstructionDetails.op
    localparam logic [3:0] OPC_ARITH = 4'd0;
    localparam logic [3:0] OPC_AR_IM = 4'd1;
    localparam logic [3:0] OPC_TEST  = 4'd2;
    localparam logic [3:0] OPC_TS_IM = 4'd3;
    localparam logic [3:0] OPC_LOAD  = 4'd4;
    localparam logic [3:0] OPC_STORE = 4'd5;
    localparam logic [3:0] OPC_BNEZ  = 4'd6;
    localparam logic [3:0] OPC_BEQZ  = 4'd7;
    localparam logic [3:0] OPC_JUMP  = 4'd8;

    // Decoded instruction as produced by the ALU stage
    typedef struct packed {
        logic       is_valid;
        logic [3:0] op;
        logic [3:0] rt;   // store-data source register
        logic [3:0] rd;   // destination register
    } InstructionDetails;

    // Data-memory access state of the MEM/WB stage
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } MemState;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == OPC_ARITH) || (op == OPC_AR_IM);
    endfunction

endpackage

// File: rtl/mem_wb_stage_timer.sv
// mem_req_timer: counts cycles spent waiting for a memory acknowledge and
// flags expiry. ACK_TIMEOUT of 0 means the timer never expires.
import types::*;

module mem_req_timer #(
    parameter int ACK_TIMEOUT = 64,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst_sync_n,
    input  logic i_start,    // request issued this cycle; counting restarts
    input  logic i_run,      // request currently outstanding
    input  logic i_ack,      // acknowledge seen this cycle
    output logic o_expire    // last permitted cycle passed without ack
);

    localparam logic [TO_W-1:0] LIMIT =
        TO_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

    logic [TO_W-1:0] r_count;

    // Wait counter: cleared when a request starts, advances each unanswered cycle
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it sits inside the
        // clocked block rather than in the sensitivity list.
        if (!rst_sync_n) begin
            r_count <= '0;
        end else if (i_start) begin
            // NOTE: non-blocking assignment keeps every flop updating from
            // pre-edge values, independent of statement order.
            r_count <= '0;
        end else if (i_run && !i_ack) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    // An ack in the final cycle still wins over expiry
    assign o_expire = (ACK_TIMEOUT != 0) && i_run && !i_ack && (r_count == LIMIT);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: retires ALU results to the register file and runs
// loads/stores over a single-outstanding req/ack data-memory port, stalling
// upstream while an access is in flight.
import types::*;

module mem_wb_stage #(
    parameter int ACK_TIMEOUT = 64,
    parameter int TO_W        = 8
) (
    input  logic              clk,
    input  logic              rst_sync_n,
    input  logic [31:0]       in_data,
    input  InstructionDetails in_details,
    output logic              in_ready,
    output logic [3:0]        st_index,
    input  logic [31:0]       st_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_en,
    output logic [3:0]        wb_index,
    output logic [31:0]       wb_data,
    output logic              err,
    input  logic              err_clear
);

    MemState     r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_ld_rd;
    logic        r_wb_en;
    logic [3:0]  r_wb_index;
    logic [31:0] r_wb_data;
    logic        r_err;

    logic w_in_req;
    logic w_accept;
    logic w_is_mem;
    logic w_misaligned;
    logic w_mem_start;
    logic w_mis_err;
    logic w_expire;
    logic w_err_set;

    assign w_in_req     = (r_state == REQ);
    assign w_accept     = in_ready && in_details.is_valid;
    assign w_is_mem     = is_mem_op(in_details.op);
    assign w_misaligned = (in_data[1:0] != 2'b00);
    assign w_mem_start  = w_accept && w_is_mem && !w_misaligned;
    assign w_mis_err    = w_accept && w_is_mem && w_misaligned;
    assign w_err_set    = w_mis_err || w_expire;

    mem_req_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timer (
        .clk        (clk),
        .rst_sync_n (rst_sync_n),
        .i_start    (w_mem_start),
        .i_run      (w_in_req),
        .i_ack      (mem_ack),
        .o_expire   (w_expire)
    );

    // Access sequencing, writeback strobe and memory-port registers
    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ld_rd     <= '0;
            r_wb_en     <= 1'b0;
            r_wb_index  <= '0;
            r_wb_data   <= '0;
        end else begin
            r_wb_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && is_arith_op(in_details.op)) begin
                        r_wb_en    <= 1'b1;
                        r_wb_index <= in_details.rd;
                        r_wb_data  <= in_data;
                    end else if (w_mem_start) begin
                        r_state     <= REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (in_details.op == OPC_STORE);
                        r_mem_addr  <= in_data;
                        r_mem_wdata <= st_data;
                        r_ld_rd     <= in_details.rd;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_wb_en    <= 1'b1;
                            r_wb_index <= r_ld_rd;
                            r_wb_data  <= mem_rdata;
                        end
                    end else if (w_expire) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky error: a new error outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clear) begin
            r_err <= 1'b0;
        end
    end

    assign in_ready  = rst_sync_n && (r_state == IDLE);
    assign st_index  = in_details.rt;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wb_en     = r_wb_en;
    assign wb_index  = r_wb_index;
    assign wb_data   = r_wb_data;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a transaction-level model tracks
// what the stage must show each cycle, and directed scenarios pin literal
// values at the interesting points.
module tb_mem_wb_stage;
    import types::*;

    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_sync_n;
    logic [31:0]       in_data;
    InstructionDetails in_details;
    logic              in_ready;
    logic [3:0]        st_index;
    logic [31:0]       st_data;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              wb_en;
    logic [3:0]        wb_index;
    logic [31:0]       wb_data;
    logic              err;
    logic              err_clear;

    int n_tests = 0;
    int n_fail  = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage #(.ACK_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk        (clk),
        .rst_sync_n (rst_sync_n),
        .in_data    (in_data),
        .in_details (in_details),
        .in_ready   (in_ready),
        .st_index   (st_index),
        .st_data    (st_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_en      (wb_en),
        .wb_index   (wb_index),
        .wb_data    (wb_data),
        .err        (err),
        .err_clear  (err_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the outstanding transaction as a whole: whether one is pending,
    // its parameters, and how many cycles it has gone unanswered.
    logic        m_busy = 0, m_we = 0, m_wb_en = 0, m_err = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_wb_data = 0;
    logic [3:0]  m_rd = 0, m_wb_index = 0;
    int          m_waited = 0;

    always @(posedge clk) begin
        logic new_err;
        new_err = 1'b0;
        m_wb_en = 1'b0;
        if (!rst_sync_n) begin
            m_busy = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_err = 0;
            m_wb_data = 0; m_wb_index = 0; m_waited = 0;
        end else begin
            if (!m_busy) begin
                if (in_details.is_valid) begin
                    if (in_details.op == OPC_ARITH || in_details.op == OPC_AR_IM) begin
                        m_wb_en = 1; m_wb_data = in_data; m_wb_index = in_details.rd;
                    end else if (in_details.op == OPC_LOAD || in_details.op == OPC_STORE) begin
                        if (in_data % 4 != 0) new_err = 1'b1;
                        else begin
                            m_busy = 1; m_waited = 0; m_addr = in_data;
                            m_we = (in_details.op == OPC_STORE);
                            m_wdata = st_data; m_rd = in_details.rd;
                        end
                    end
                end
            end else if (mem_ack) begin
                m_busy = 0;
                if (!m_we) begin
                    m_wb_en = 1; m_wb_data = mem_rdata; m_wb_index = m_rd;
                end
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_busy = 0; new_err = 1'b1;
                end
            end
            if (new_err) m_err = 1;
            else if (err_clear) m_err = 0;
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("m_in_ready", in_ready, rst_sync_n && !m_busy);
            check("m_st_index", st_index, in_details.rt);
            check("m_mem_req", mem_req, m_busy);
            check("m_wb_en", wb_en, m_wb_en);
            check("m_err", err, m_err);
            if (m_wb_en) begin
                check("m_wb_data", wb_data, m_wb_data);
                check("m_wb_index", wb_index, m_wb_index);
            end
            if (m_busy) begin
                check("m_mem_addr", mem_addr, m_addr);
                check("m_mem_we", mem_we, m_we);
                check("m_mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rt,
                         input logic [31:0] d);
        @(negedge clk);
        in_details.is_valid = 1'b1;
        in_details.op = op;
        in_details.rd = rd;
        in_details.rt = rt;
        in_data = d;
    endtask

    task automatic quiet();
        @(negedge clk);
        in_details.is_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_sync_n = 1'b0;
        in_data = '0;
        in_details = '0;
        st_data = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        err_clear = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_err", err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wb_data", wb_data, 0);
        @(negedge clk);
        rst_sync_n = 1'b1;
        cmp_en = 1'b1;
        tick();
        check("rst_release_ready", in_ready, 1);

        // Back-to-back ARITH writebacks
        drive(OPC_ARITH, 4'd3, 4'd1, 32'h1234);
        tick();
        check("ar1_wb_en", wb_en, 1);
        check("ar1_wb_index", wb_index, 3);
        check("ar1_wb_data", wb_data, 32'h1234);
        drive(OPC_AR_IM, 4'd0, 4'd2, 32'h55);
        tick();
        check("ar2_wb_en", wb_en, 1);
        check("ar2_wb_index_r0", wb_index, 0);
        check("ar2_wb_data", wb_data, 32'h55);

        // Non-writing op and invalid input: no side effects
        drive(OPC_TEST, 4'd7, 4'd0, 32'h99);
        tick();
        check("test_no_wb", wb_en, 0);
        drive(OPC_ARITH, 4'd7, 4'd0, 32'h77);
        in_details.is_valid = 1'b0;
        tick();
        check("invalid_no_wb", wb_en, 0);

        // LOAD 0x100 rd=5, ack on the third request cycle
        drive(OPC_LOAD, 4'd5, 4'd0, 32'h100);
        tick();
        check("ld_req", mem_req, 1);
        check("ld_addr", mem_addr, 32'h100);
        check("ld_we", mem_we, 0);
        check("ld_in_ready", in_ready, 0);
        quiet(); tick();
        check("ld_req_c2", mem_req, 1);
        quiet(); tick();
        check("ld_req_c3", mem_req, 1);
        check("ld_addr_c3", mem_addr, 32'h100);
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        check("ld_req_done", mem_req, 0);
        check("ld_wb_en", wb_en, 1);
        check("ld_wb_data", wb_data, 32'hDEADBEEF);
        check("ld_wb_index", wb_index, 5);
        check("ld_ready", in_ready, 1);
        @(negedge clk);
        mem_ack = 1'b0;

        // STORE 0x200 with immediate ack
        drive(OPC_STORE, 4'd1, 4'd9, 32'h200);
        st_data = 32'hCAFEF00D;
        tick();
        check("st_req", mem_req, 1);
        check("st_we", mem_we, 1);
        check("st_wdata", mem_wdata, 32'hCAFEF00D);
        quiet();
        mem_ack = 1'b1;
        tick();
        check("st_no_wb", wb_en, 0);
        check("st_ready", in_ready, 1);
        @(negedge clk);
        mem_ack = 1'b0;

        // Misaligned LOAD, then clear
        drive(OPC_LOAD, 4'd2, 4'd0, 32'h102);
        tick();
        check("mis_no_req", mem_req, 0);
        check("mis_err", err, 1);
        check("mis_no_wb", wb_en, 0);
        quiet();
        err_clear = 1'b1;
        tick();
        check("mis_cleared", err, 0);
        // New error in the same cycle as a clear keeps err set
        drive(OPC_STORE, 4'd2, 4'd0, 32'h3);
        tick();
        check("mis_clear_race", err, 1);
        quiet(); tick();
        check("mis_clear2", err, 0);
        @(negedge clk);
        err_clear = 1'b0;

        // Timeout: request held exactly TIMEOUT cycles
        drive(OPC_LOAD, 4'd6, 4'd0, 32'h300);
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            check("to_req_held", mem_req, 1);
            quiet();
        end
        tick();
        check("to_req_drop", mem_req, 0);
        check("to_err", err, 1);
        check("to_ready", in_ready, 1);
        check("to_no_wb", wb_en, 0);
        @(negedge clk);
        err_clear = 1'b1;
        tick();
        @(negedge clk);
        err_clear = 1'b0;

        // Ack on the final permitted cycle wins over expiry
        drive(OPC_LOAD, 4'd9, 4'd0, 32'h304);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            quiet();
        end
        mem_ack = 1'b1;
        mem_rdata = 32'h0BADF00D;
        tick();
        check("to_ack_wb_en", wb_en, 1);
        check("to_ack_wb_data", wb_data, 32'h0BADF00D);
        check("to_ack_wb_index", wb_index, 9);
        check("to_ack_no_err", err, 0);
        @(negedge clk);
        mem_ack = 1'b0;

        // Reset during REQ, then a stale ack
        drive(OPC_LOAD, 4'd4, 4'd0, 32'h400);
        tick();
        check("rr_req", mem_req, 1);
        quiet();
        rst_sync_n = 1'b0;
        tick();
        check("rr_req_drop", mem_req, 0);
        check("rr_no_wb", wb_en, 0);
        check("rr_ready_low", in_ready, 0);
        @(negedge clk);
        rst_sync_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h11111111;
        tick();
        check("rr_stale_no_wb", wb_en, 0);
        check("rr_stale_no_req", mem_req, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
